// File: rtl/axi_pkg.sv
// Shared AXI3 types and widths for the slave memory and its address generator.
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_e;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, plus a flag for
// burst shapes this slave refuses (size > 4 bytes, reserved burst, bad WRAP length).
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              illegal
);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] mask;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    bytes     = ADDR_W'(1) << size;
    mask      = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    next_addr = addr;
    illegal   = (size > 3'd2);
    case (burst_e'(burst))
      FIXED: next_addr = addr;
      INCR:  next_addr = addr + bytes;
      WRAP: begin
        next_addr = (addr & ~mask) | ((addr + bytes) & mask);
        if (!(len inside {4'd1, 4'd3, 4'd7, 4'd15})) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 slave backed by a word memory; independent write and read engines, one burst each.
// Define AXI_SLV_RANGE_CHK_EN to reject (SLVERR) beats outside BASE_ADDR..BASE_ADDR+4*MEM_DEPTH-1.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int                MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   wid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t word_idx(input logic [ADDR_W-1:0] a);
    return idx_t'((a - BASE_ADDR) >> 2);
  endfunction

  logic unused_sideband;
  assign unused_sideband = ^{awlock, awcache, awprot, arlock, arcache, arprot};

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              rst_q;

  // ---------------- write engine ----------------
  wstate_e           w_state, w_next;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr, wg_addr, wg_next;
  logic [LEN_W-1:0]  w_len, w_beat, wg_len;
  logic [2:0]        w_size, wg_size;
  logic [1:0]        w_burst, wg_burst;
  logic              w_err, wg_illegal, w_rng_err;
  logic              aw_fire, w_fire, w_beat_bad, w_we;

  // In idle the generator checks the incoming AW burst; afterwards the latched one.
  assign wg_addr  = (w_state == W_IDLE) ? awaddr  : w_addr;
  assign wg_size  = (w_state == W_IDLE) ? awsize  : w_size;
  assign wg_len   = (w_state == W_IDLE) ? awlen   : w_len;
  assign wg_burst = (w_state == W_IDLE) ? awburst : w_burst;

  axi_burst_addr_gen u_wr_gen (
    .addr(wg_addr), .size(wg_size), .len(wg_len), .burst(wg_burst),
    .next_addr(wg_next), .illegal(wg_illegal)
  );

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready = !rst_q;
        if (awvalid && !rst_q) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_beat == w_len) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_fire    = awvalid && awready;
  assign w_fire     = wvalid && wready;
  assign w_beat_bad = (wid != w_id) || (wlast && w_beat != w_len) || w_rng_err;
  assign w_we       = w_fire && !arst && (wid == w_id) && !w_rng_err;
  assign bid        = w_id;
  assign bresp      = w_err ? SLVERR : OKAY;

  // ---------------- read engine ----------------
  rstate_e           r_state, r_next;
  logic [ADDR_W-1:0] r_addr, rg_addr, rg_next, r_load_addr;
  logic [LEN_W-1:0]  r_len, r_beat, rg_len;
  logic [2:0]        r_size, rg_size;
  logic [1:0]        r_burst, rg_burst;
  logic              rg_illegal, r_rng_err, ar_fire, r_fire;
  logic [DATA_W-1:0] r_load_data;

  assign rg_addr     = (r_state == R_IDLE) ? araddr  : r_addr;
  assign rg_size     = (r_state == R_IDLE) ? arsize  : r_size;
  assign rg_len      = (r_state == R_IDLE) ? arlen   : r_len;
  assign rg_burst    = (r_state == R_IDLE) ? arburst : r_burst;
  assign r_load_addr = (r_state == R_IDLE) ? araddr  : rg_next;

  axi_burst_addr_gen u_rd_gen (
    .addr(rg_addr), .size(rg_size), .len(rg_len), .burst(rg_burst),
    .next_addr(rg_next), .illegal(rg_illegal)
  );

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready = !rst_q;
        if (arvalid && !rst_q) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) r_next = R_IDLE;
      end
    endcase
  end

  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;

`ifdef AXI_SLV_RANGE_CHK_EN
  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return (a < BASE_ADDR) || (((a - BASE_ADDR) >> 2) >= ADDR_W'(MEM_DEPTH));
  endfunction
  assign w_rng_err = out_of_range(w_addr);
  assign r_rng_err = out_of_range(r_load_addr);
`else
  assign w_rng_err = 1'b0;
  assign r_rng_err = 1'b0;
`endif

  assign r_load_data = r_rng_err ? '0 : mem[word_idx(r_load_addr)];

  // ---------------- sequential state ----------------
  // NOTE: reset is synchronous; arst only takes effect at a rising aclk edge.
  always_ff @(posedge aclk) begin
    rst_q <= arst;
    if (arst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
    end else if (aw_fire) begin
      w_id    <= awid;
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_beat  <= '0;
      w_err   <= wg_illegal;
    end else if (w_fire) begin
      w_addr <= wg_next;
      w_beat <= w_beat + LEN_W'(1);
      if (w_beat_bad) w_err <= 1'b1;
    end
  end

  // NOTE: the memory array has no reset; its contents deliberately survive arst.
  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // NOTE: non-blocking update means a same-edge write to the word being loaded is not seen (old data returned).
  always_ff @(posedge aclk) begin
    if (arst) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
    end else if (ar_fire) begin
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_beat  <= '0;
      rid     <= arid;
      rdata   <= r_load_data;
      rresp   <= (rg_illegal || r_rng_err) ? SLVERR : OKAY;
      rlast   <= (arlen == '0);
    end else if (r_fire && !rlast) begin
      r_addr <= rg_next;
      r_beat <= r_beat + LEN_W'(1);
      rdata  <= r_load_data;
      rresp  <= (rg_illegal || r_rng_err) ? SLVERR : OKAY;
      rlast  <= ((r_beat + LEN_W'(1)) == r_len);
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem: single, INCR, WRAP, FIXED, backpressure, errors, reset.
module tb_axi_slave_mem;
  import axi_pkg::*;

  localparam int          MEM_DEPTH = 1024;
  localparam logic [31:0] BASE      = 32'h0;
  localparam int          TMO       = 50;

  logic        aclk = 1'b0, arst = 1'b1;
  logic [3:0]  awid = '0, wid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [3:0]  awlen = '0, arlen = '0, wstrb = '0, awcache = '0, arcache = '0;
  logic [2:0]  awsize = '0, arsize = '0, awprot = '0, arprot = '0;
  logic [1:0]  awburst = '0, arburst = '0, awlock = '0, arlock = '0, bresp, rresp;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;

  always #5 aclk = ~aclk;

  axi_slave_mem #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE)) dut (
    .aclk(aclk), .arst(arst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int total = 0, bad = 0;

  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id   [16];
  logic [3:0]  b_id;
  logic [1:0]  b_resp;

  // ---------------- bus drivers (all entered and left on a falling edge) ----------------
  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
    if (awready !== 1'b1) begin total++; bad++; $display("FAIL aw_timeout: awready=%b want 1", awready); end
    @(negedge aclk); awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (wready !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
    if (wready !== 1'b1) begin total++; bad++; $display("FAIL w_timeout: wready=%b want 1", wready); end
    @(negedge aclk); wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_wait();
    int n = 0;
    bready = 1'b1;
    while (bvalid !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
    if (bvalid !== 1'b1) begin total++; bad++; $display("FAIL b_timeout: bvalid=%b want 1", bvalid); end
    b_id = bid; b_resp = bresp;
    @(negedge aclk); bready = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (arready !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
    if (arready !== 1'b1) begin total++; bad++; $display("FAIL ar_timeout: arready=%b want 1", arready); end
    @(negedge aclk); arvalid = 1'b0;
  endtask

  task automatic r_take(input int k);
    int n = 0;
    rready = 1'b1;
    while (rvalid !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
    if (rvalid !== 1'b1) begin total++; bad++; $display("FAIL r_timeout: rvalid=%b want 1", rvalid); end
    rd_data[k] = rdata; rd_last[k] = rlast; rd_resp[k] = rresp; rd_id[k] = rid;
    @(negedge aclk); rready = 1'b0;
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    aw_send(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) w_send(id, wr_data[i], wr_strb[i], i == int'(len));
    b_wait();
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    ar_send(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) r_take(i);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst = 1'b1;
    repeat (3) @(negedge aclk);
    total++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0 || {bid, bresp, rid, rresp} !== 12'h0 || rdata !== 32'h0) begin
      bad++; $display("FAIL reset_outputs: awready=%b wready=%b bvalid=%b arready=%b rvalid=%b rdata=%h want all 0",
                      awready, wready, bvalid, arready, rvalid, rdata);
    end
    arst = 1'b0;
    total++;
    if (awready !== 1'b0 || arready !== 1'b0) begin
      bad++; $display("FAIL reset_release_same_cycle: awready=%b arready=%b want 0 0", awready, arready);
    end
    @(negedge aclk);
    total++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      bad++; $display("FAIL reset_ready_after: awready=%b arready=%b want 1 1", awready, arready);
    end
  endtask

  task automatic test_single();
    aw_send(4'h5, 32'h10, 4'd0, 3'd2, INCR);
    w_send(4'h5, 32'hDEADBEEF, 4'hF, 1'b1);
    total++;
    if (bvalid !== 1'b1) begin bad++; $display("FAIL single_b_latency: bvalid=%b want 1", bvalid); end
    b_wait();
    total++;
    if (b_id !== 4'h5 || b_resp !== 2'b00) begin
      bad++; $display("FAIL single_b: bid=%h bresp=%b want 5 00", b_id, b_resp);
    end
    rd_burst(4'hA, 32'h10, 4'd0, 3'd2, INCR);
    total++;
    if (rd_data[0] !== 32'hDEADBEEF || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00 || rd_id[0] !== 4'hA) begin
      bad++; $display("FAIL single_r: rdata=%h rlast=%b rresp=%b rid=%h want deadbeef 1 00 a",
                      rd_data[0], rd_last[0], rd_resp[0], rd_id[0]);
    end
  endtask

  task automatic test_range();
`ifdef AXI_SLV_RANGE_CHK_EN
    rd_burst(4'h1, BASE + 32'(4 * MEM_DEPTH), 4'd0, 3'd2, INCR);
    total++;
    if (rd_resp[0] !== 2'b10 || rd_data[0] !== 32'h0) begin
      bad++; $display("FAIL range_read: rresp=%b rdata=%h want 10 0", rd_resp[0], rd_data[0]);
    end
    wr_data[0] = 32'hCAFEF00D; wr_strb[0] = 4'hF;
    wr_burst(4'h1, BASE + 32'(4 * MEM_DEPTH) + 32'h10, 4'd0, 3'd2, INCR);
    total++;
    if (b_resp !== 2'b10) begin bad++; $display("FAIL range_write: bresp=%b want 10", b_resp); end
    rd_burst(4'h1, 32'h10, 4'd0, 3'd2, INCR);
    total++;
    if (rd_data[0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL range_write_suppressed: rdata=%h want deadbeef", rd_data[0]);
    end
`else
    rd_burst(4'h1, 32'h1010, 4'd0, 3'd2, INCR);
    total++;
    if (rd_data[0] !== 32'hDEADBEEF || rd_resp[0] !== 2'b00) begin
      bad++; $display("FAIL alias_read: rdata=%h rresp=%b want deadbeef 00", rd_data[0], rd_resp[0]);
    end
    wr_data[0] = 32'hCAFEF00D; wr_strb[0] = 4'hF;
    wr_burst(4'h1, 32'h1014, 4'd0, 3'd2, INCR);
    rd_burst(4'h1, 32'h14, 4'd0, 3'd2, INCR);
    total++;
    if (b_resp !== 2'b00 || rd_data[0] !== 32'hCAFEF00D) begin
      bad++; $display("FAIL alias_write: bresp=%b rdata=%h want 00 cafef00d", b_resp, rd_data[0]);
    end
`endif
  endtask

  task automatic test_incr();
    logic [31:0] exp_d [4] = '{32'h1, 32'h2, 32'hAAAA0003, 32'h4};
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hAAAAAAAA; wr_strb[i] = 4'hF; end
    wr_burst(4'h1, 32'h20, 4'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = (i == 2) ? 4'b0011 : 4'hF; end
    wr_burst(4'h2, 32'h20, 4'd3, 3'd2, INCR);
    total++;
    if (b_resp !== 2'b00 || b_id !== 4'h2) begin bad++; $display("FAIL incr_b: bresp=%b bid=%h want 00 2", b_resp, b_id); end
    rd_burst(4'h3, 32'h20, 4'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data[i] !== exp_d[i] || rd_last[i] !== (i == 3)) begin
        bad++; $display("FAIL incr_beat%0d: rdata=%h rlast=%b want %h %b", i, rd_data[i], rd_last[i], exp_d[i], i == 3);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_incr [4] = '{32'h102, 32'h103, 32'h100, 32'h101};
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h100 + 32'(i); wr_strb[i] = 4'hF; end
    wr_burst(4'h4, 32'h38, 4'd3, 3'd2, WRAP);
    total++;
    if (b_resp !== 2'b00) begin bad++; $display("FAIL wrap_b: bresp=%b want 00", b_resp); end
    rd_burst(4'h4, 32'h30, 4'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data[i] !== exp_incr[i]) begin
        bad++; $display("FAIL wrap_layout%0d: rdata=%h want %h", i, rd_data[i], exp_incr[i]);
      end
    end
    rd_burst(4'h5, 32'h38, 4'd3, 3'd2, WRAP);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data[i] !== 32'h100 + 32'(i) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
        bad++; $display("FAIL wrap_read%0d: rdata=%h rresp=%b rlast=%b want %h 00 %b",
                        i, rd_data[i], rd_resp[i], rd_last[i], 32'h100 + 32'(i), i == 3);
      end
    end
  endtask

  task automatic test_fixed();
    wr_data[0] = 32'hF0F0F0F0; wr_data[1] = 32'h0F0F0F0F; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    wr_burst(4'h1, 32'h70, 4'd1, 3'd2, INCR);
    wr_data[0] = 32'h11; wr_data[1] = 32'h22;
    wr_burst(4'h1, 32'h70, 4'd1, 3'd2, FIXED);
    rd_burst(4'h1, 32'h70, 4'd1, 3'd2, INCR);
    total++;
    if (rd_data[0] !== 32'h22 || rd_data[1] !== 32'h0F0F0F0F) begin
      bad++; $display("FAIL fixed: rdata0=%h rdata1=%h want 22 0f0f0f0f", rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_back_to_back_pressure();
    aw_send(4'h9, 32'h40, 4'd1, 3'd2, INCR);
    w_send(4'h9, 32'h12345678, 4'hF, 1'b0);
    w_send(4'h9, 32'h9ABCDEF0, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bvalid !== 1'b1 || bid !== 4'h9 || bresp !== 2'b00 || awready !== 1'b0) begin
        bad++; $display("FAIL bp_b_hold%0d: bvalid=%b bid=%h bresp=%b awready=%b want 1 9 00 0", i, bvalid, bid, bresp, awready);
      end
      @(negedge aclk);
    end
    b_wait();
    total++;
    if (awready !== 1'b1) begin bad++; $display("FAIL bp_awready_after: awready=%b want 1", awready); end
    ar_send(4'h6, 32'h40, 4'd1, 3'd2, INCR);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rvalid !== 1'b1 || rid !== 4'h6 || rdata !== 32'h12345678 || rlast !== 1'b0 || arready !== 1'b0) begin
        bad++; $display("FAIL bp_r_hold%0d: rvalid=%b rid=%h rdata=%h rlast=%b arready=%b want 1 6 12345678 0 0",
                        i, rvalid, rid, rdata, rlast, arready);
      end
      @(negedge aclk);
    end
    r_take(0); r_take(1);
    total++;
    if (rd_data[0] !== 32'h12345678 || rd_data[1] !== 32'h9ABCDEF0 || rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1) begin
      bad++; $display("FAIL bp_r_data: d0=%h d1=%h l0=%b l1=%b want 12345678 9abcdef0 0 1", rd_data[0], rd_data[1], rd_last[0], rd_last[1]);
    end
    total++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      bad++; $display("FAIL bp_r_done: arready=%b rvalid=%b want 1 0", arready, rvalid);
    end
  endtask

  task automatic test_errors();
    wr_data[0] = 32'h50505050; wr_data[1] = 32'h54545454; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    wr_burst(4'h3, 32'h50, 4'd1, 3'd2, INCR);
    aw_send(4'h3, 32'h50, 4'd1, 3'd2, INCR);
    w_send(4'h3, 32'h11111111, 4'hF, 1'b0);
    w_send(4'h7, 32'h22222222, 4'hF, 1'b1);
    b_wait();
    total++;
    if (b_resp !== 2'b10 || b_id !== 4'h3) begin bad++; $display("FAIL err_wid_b: bresp=%b bid=%h want 10 3", b_resp, b_id); end
    rd_burst(4'h3, 32'h50, 4'd1, 3'd2, INCR);
    total++;
    if (rd_data[0] !== 32'h11111111 || rd_data[1] !== 32'h54545454) begin
      bad++; $display("FAIL err_wid_data: d0=%h d1=%h want 11111111 54545454", rd_data[0], rd_data[1]);
    end
    aw_send(4'h3, 32'h60, 4'd0, 3'd3, INCR);
    w_send(4'h3, 32'h33333333, 4'hF, 1'b1);
    b_wait();
    total++;
    if (b_resp !== 2'b10) begin bad++; $display("FAIL err_awsize: bresp=%b want 10", b_resp); end
    aw_send(4'h2, 32'h58, 4'd1, 3'd2, INCR);
    w_send(4'h2, 32'h44444444, 4'hF, 1'b1);
    w_send(4'h2, 32'h55555555, 4'hF, 1'b1);
    b_wait();
    total++;
    if (b_resp !== 2'b10) begin bad++; $display("FAIL err_early_wlast: bresp=%b want 10", b_resp); end
    wr_data[0] = 32'h66666666; wr_strb[0] = 4'hF;
    wr_burst(4'h2, 32'h5C, 4'd0, 3'd2, INCR);
    total++;
    if (b_resp !== 2'b00) begin bad++; $display("FAIL err_cleared: bresp=%b want 00", b_resp); end
    rd_burst(4'h2, 32'h50, 4'd0, 3'd3, INCR);
    total++;
    if (rd_resp[0] !== 2'b10) begin bad++; $display("FAIL err_arsize: rresp=%b want 10", rd_resp[0]); end
    rd_burst(4'h2, 32'h50, 4'd2, 3'd2, WRAP);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 2)) begin
        bad++; $display("FAIL err_wrap_len%0d: rresp=%b rlast=%b want 10 %b", i, rd_resp[i], rd_last[i], i == 2);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = 4'hF; end
    wr_burst(4'h1, 32'h80, 4'd3, 3'd2, INCR);
    ar_send(4'h8, 32'h80, 4'd3, 3'd2, INCR);
    r_take(0); r_take(1);
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'hA2) begin bad++; $display("FAIL rst_mid_beat2: rvalid=%b rdata=%h want 1 a2", rvalid, rdata); end
    arst = 1'b1;
    @(negedge aclk);
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || awready !== 1'b0) begin
      bad++; $display("FAIL rst_mid_abort: rvalid=%b arready=%b awready=%b want 0 0 0", rvalid, arready, awready);
    end
    arst = 1'b0;
    @(negedge aclk);
    total++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_ready: arready=%b rvalid=%b want 1 0", arready, rvalid);
    end
    rd_burst(4'h9, 32'h80, 4'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data[i] !== 32'hA0 + 32'(i)) begin
        bad++; $display("FAIL rst_mid_mem%0d: rdata=%h want %h", i, rd_data[i], 32'hA0 + 32'(i));
      end
    end
    rd_burst(4'h9, 32'h10, 4'd0, 3'd2, INCR);
    total++;
    if (rd_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rst_mid_retain: rdata=%h want deadbeef", rd_data[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_range();
    test_incr();
    test_wrap();
    test_fixed();
    test_back_to_back_pressure();
    test_errors();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
